// File: rtl/cache_mem_responder_if.sv
// Cache-to-memory request bus: read request/beat channel and write request/beat channel.
// master = cache-side initiator, slave = memory responder.
interface cache_mem_responder_if;
    logic        r_req;
    logic [31:0] r_addr;
    logic [7:0]  r_length;
    logic [2:0]  r_size;
    logic        r_rdy;
    logic [31:0] r_data;
    logic        r_data_valid;
    logic        r_data_last;
    logic        r_data_ready;

    logic        w_req;
    logic [31:0] w_addr;
    logic [7:0]  w_length;
    logic [2:0]  w_size;
    logic        w_rdy;
    logic [31:0] w_data;
    logic        w_data_valid;
    logic        w_data_ready;
    logic        wrt_finish;

    modport master (
        output r_req, r_addr, r_length, r_size, r_data_ready,
               w_req, w_addr, w_length, w_size, w_data, w_data_valid,
        input  r_rdy, r_data, r_data_valid, r_data_last,
               w_rdy, w_data_ready, wrt_finish
    );

    modport slave (
        input  r_req, r_addr, r_length, r_size, r_data_ready,
               w_req, w_addr, w_length, w_size, w_data, w_data_valid,
        output r_rdy, r_data, r_data_valid, r_data_last,
               w_rdy, w_data_ready, wrt_finish
    );
endinterface

// File: rtl/cache_mem_responder.sv
// cache_mem_responder: memory-side responder for cache refill/writeback bursts,
// backed by an on-chip word RAM. Writes win over reads when both are pending.
// Optional build macro RESP_STALL_EN adds LFSR-driven read bubbles and write
// back-pressure to exercise initiator stall paths.
module cache_mem_responder #(
    parameter int unsigned MEM_AW       = 12,
    parameter int unsigned W_RESP_DELAY = 2
) (
    input  logic                 clk,
    input  logic                 rstn,
    cache_mem_responder_if.slave bus,
    output logic                 busy
);
    localparam int unsigned DEPTH = 1 << MEM_AW;
    localparam int unsigned DLY_W = (W_RESP_DELAY > 1) ? $clog2(W_RESP_DELAY) : 1;

    typedef enum logic [1:0] {IDLE, RDATA, WDATA, WRESP} state_t;

    state_t            state_q;
    logic [31:0]       addr_q;
    logic [7:0]        cnt_q;
    logic [2:0]        size_q;
    logic [DLY_W-1:0]  dly_q;

    logic [31:0]       step_c;
    logic [3:0]        strb_c;
    logic [MEM_AW-1:0] idx_c;
    logic              mem_we_c;
    logic              bubble_c;
    logic              wready_nxt_c;

    logic [31:0]       mem [DEPTH];

`ifdef RESP_STALL_EN
    logic [7:0] lfsr_q;
    logic [7:0] lfsr_nxt_c;

    assign lfsr_nxt_c = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

    // Free-running stall pattern generator.
    always_ff @(posedge clk) begin
        if (!rstn) lfsr_q <= 8'hA5;
        else       lfsr_q <= lfsr_nxt_c;
    end

    assign bubble_c     = lfsr_q[0];
    assign wready_nxt_c = ~lfsr_nxt_c[1];
`else
    assign bubble_c     = 1'b0;
    assign wready_nxt_c = 1'b1;
`endif

    // Per-beat address increment and byte-lane strobe from the latched size.
    always_comb begin
        step_c = 32'd4;
        strb_c = 4'hF;
        if (size_q == 3'd0) begin
            step_c = 32'd1;
            strb_c = 4'b0001 << addr_q[1:0];
        end else if (size_q == 3'd1) begin
            step_c = 32'd2;
            strb_c = 4'b0011 << {addr_q[1], 1'b0};
        end
    end

    assign idx_c    = addr_q[MEM_AW+1:2];
    assign mem_we_c = rstn && (state_q == WDATA) && bus.w_data_valid && bus.w_data_ready;

    // Word RAM write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            for (int i = 0; i < 4; i++) begin
                if (strb_c[i]) mem[idx_c][8*i +: 8] <= bus.w_data[8*i +: 8];
            end
        end
    end

    // Request arbitration, burst sequencing and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q          <= IDLE;
            addr_q           <= 32'd0;
            cnt_q            <= 8'd0;
            size_q           <= 3'd0;
            dly_q            <= '0;
            busy             <= 1'b0;
            bus.r_rdy        <= 1'b0;
            bus.r_data       <= 32'd0;
            bus.r_data_valid <= 1'b0;
            bus.r_data_last  <= 1'b0;
            bus.w_rdy        <= 1'b0;
            bus.w_data_ready <= 1'b0;
            bus.wrt_finish   <= 1'b0;
        end else begin
            bus.r_rdy      <= 1'b0;
            bus.w_rdy      <= 1'b0;
            bus.wrt_finish <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.w_req) begin
                        bus.w_rdy        <= 1'b1;
                        bus.w_data_ready <= wready_nxt_c;
                        addr_q           <= bus.w_addr;
                        cnt_q            <= bus.w_length;
                        size_q           <= bus.w_size;
                        state_q          <= WDATA;
                        busy             <= 1'b1;
                    end else if (bus.r_req) begin
                        bus.r_rdy <= 1'b1;
                        addr_q    <= bus.r_addr;
                        cnt_q     <= bus.r_length;
                        size_q    <= bus.r_size;
                        state_q   <= RDATA;
                        busy      <= 1'b1;
                    end
                end
                RDATA: begin
                    if (!bus.r_data_valid) begin
                        bus.r_data       <= mem[idx_c];
                        bus.r_data_valid <= 1'b1;
                        bus.r_data_last  <= (cnt_q == 8'd0);
                        addr_q           <= addr_q + step_c;
                    end else if (bus.r_data_ready) begin
                        if (cnt_q == 8'd0) begin
                            bus.r_data_valid <= 1'b0;
                            bus.r_data_last  <= 1'b0;
                            state_q          <= IDLE;
                            busy             <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q - 8'd1;
                            if (bubble_c) begin
                                bus.r_data_valid <= 1'b0;
                                bus.r_data_last  <= 1'b0;
                            end else begin
                                bus.r_data      <= mem[idx_c];
                                bus.r_data_last <= (cnt_q == 8'd1);
                                addr_q          <= addr_q + step_c;
                            end
                        end
                    end
                end
                WDATA: begin
                    if (bus.w_data_valid && bus.w_data_ready) begin
                        addr_q <= addr_q + step_c;
                        if (cnt_q == 8'd0) begin
                            bus.w_data_ready <= 1'b0;
                            if (W_RESP_DELAY <= 1) begin
                                bus.wrt_finish <= 1'b1;
                                state_q        <= IDLE;
                                busy           <= 1'b0;
                            end else begin
                                dly_q   <= DLY_W'(W_RESP_DELAY - 1);
                                state_q <= WRESP;
                            end
                        end else begin
                            cnt_q            <= cnt_q - 8'd1;
                            bus.w_data_ready <= wready_nxt_c;
                        end
                    end else begin
                        bus.w_data_ready <= wready_nxt_c;
                    end
                end
                WRESP: begin
                    if (dly_q <= DLY_W'(1)) begin
                        bus.wrt_finish <= 1'b1;
                        state_q        <= IDLE;
                        busy           <= 1'b0;
                    end else begin
                        dly_q <= dly_q - DLY_W'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_cache_mem_responder.sv
// Bench for cache_mem_responder: drives read/write bursts as a cache would and
// scores returned beats against a word-level memory model.
module tb_cache_mem_responder;
    localparam int unsigned MEM_AW       = 12;
    localparam int unsigned W_RESP_DELAY = 2;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    logic busy;

    cache_mem_responder_if bus ();

    cache_mem_responder #(.MEM_AW(MEM_AW), .W_RESP_DELAY(W_RESP_DELAY)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus),
        .busy (busy)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] model [int];
    logic [31:0] exp_q [$];
    logic [31:0] got_q [$];
    logic        got_last_q [$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] step_of(input logic [2:0] s);
        return (s == 3'd0) ? 32'd1 : (s == 3'd1) ? 32'd2 : 32'd4;
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'(a[MEM_AW+1:2]);
    endfunction

    function automatic void model_write(input logic [31:0] a, input logic [2:0] s, input logic [31:0] d);
        logic [3:0]  st;
        logic [31:0] w;
        int          ix;
        ix = widx(a);
        st = (s == 3'd0) ? (4'b0001 << a[1:0]) : (s == 3'd1) ? (4'b0011 << {a[1], 1'b0}) : 4'hF;
        w  = model.exists(ix) ? model[ix] : 32'hxxxx_xxxx;
        for (int i = 0; i < 4; i++) if (st[i]) w[8*i +: 8] = d[8*i +: 8];
        model[ix] = w;
    endfunction

    function automatic void push_exp(input logic [31:0] a, input logic [7:0] len, input logic [2:0] s);
        logic [31:0] p;
        p = a;
        for (int j = 0; j <= int'(len); j++) begin
            exp_q.push_back(model.exists(widx(p)) ? model[widx(p)] : 32'hxxxx_xxxx);
            p = p + step_of(s);
        end
    endfunction

    // Drives one write burst with data base+i; abort_at >= 0 pulls rstn on that beat.
    task automatic do_write(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                            input logic [31:0] base, input int abort_at,
                            output int rdy_lat, output int fin_lat, output bit rd_seen, output bit aborted);
        logic [31:0] a;
        int          i;
        int          g;
        bit          hs;
        rd_seen = 1'b0;
        aborted = 1'b0;
        fin_lat = -1;
        bus.w_req = 1'b1; bus.w_addr = addr; bus.w_length = len; bus.w_size = size;
        rdy_lat = 0;
        do begin
            tick(); rdy_lat++;
            if (bus.r_rdy) rd_seen = 1'b1;
        end while (!bus.w_rdy && rdy_lat < 50);
        bus.w_req = 1'b0;
        if (!bus.w_rdy) return;
        a = addr; i = 0; g = 0;
        bus.w_data_valid = 1'b1;
        bus.w_data       = base;
        while (i <= int'(len) && g < 1000) begin
            hs = bus.w_data_ready;
            if (hs && i == abort_at) begin
                rstn = 1'b0;
                tick();
                aborted = 1'b1;
                bus.w_data_valid = 1'b0;
                return;
            end
            if (hs) model_write(a, size, bus.w_data);
            tick(); g++;
            if (bus.r_rdy) rd_seen = 1'b1;
            if (hs) begin
                i++;
                a = a + step_of(size);
                bus.w_data = base + 32'(i);
            end
        end
        bus.w_data_valid = 1'b0;
        fin_lat = 1;
        while (!bus.wrt_finish && fin_lat < 20) begin
            tick(); fin_lat++;
            if (bus.r_rdy) rd_seen = 1'b1;
        end
    endtask

    // Issues one read burst and collects accepted beats into got_q/got_last_q.
    task automatic do_read(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                           input bit toggle, output int rdy_lat, output int first_lat, output int last_k,
                           output int held_bad, output logic end_valid, output logic end_busy);
        int          k;
        bit          rd;
        bit          pend;
        logic [31:0] pd;
        bus.r_req = 1'b1; bus.r_addr = addr; bus.r_length = len; bus.r_size = size;
        rdy_lat = 0;
        do begin tick(); rdy_lat++; end while (!bus.r_rdy && rdy_lat < 50);
        bus.r_req = 1'b0;
        got_q.delete(); got_last_q.delete();
        first_lat = -1; last_k = -1; held_bad = 0; pend = 1'b0; pd = 32'd0;
        if (bus.r_rdy) begin
            k = 0;
            while (got_q.size() < int'(len) + 1 && k < 3000) begin
                tick(); k++;
                rd = toggle ? (((k - 1) % 4 == 0) || ((k - 1) % 4 == 3)) : 1'b1;
                bus.r_data_ready = rd;
                if (pend && (!bus.r_data_valid || bus.r_data !== pd)) held_bad++;
                if (bus.r_data_valid) begin
                    if (first_lat < 0) first_lat = k;
                    if (rd) begin
                        got_q.push_back(bus.r_data);
                        got_last_q.push_back(bus.r_data_last);
                        last_k = k;
                    end
                    pend = !rd;
                    pd   = bus.r_data;
                end else begin
                    pend = 1'b0;
                end
            end
            tick();
            bus.r_data_ready = 1'b0;
        end
        end_valid = bus.r_data_valid;
        end_busy  = busy;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (3) tick();
        n_vec++; if (bus.r_rdy !== 1'b0)        begin n_err++; $display("FAIL rst_r_rdy got %b want 0", bus.r_rdy); end
        n_vec++; if (bus.r_data !== 32'd0)      begin n_err++; $display("FAIL rst_r_data got %h want 0", bus.r_data); end
        n_vec++; if (bus.r_data_valid !== 1'b0) begin n_err++; $display("FAIL rst_r_valid got %b want 0", bus.r_data_valid); end
        n_vec++; if (bus.r_data_last !== 1'b0)  begin n_err++; $display("FAIL rst_r_last got %b want 0", bus.r_data_last); end
        n_vec++; if (bus.w_rdy !== 1'b0)        begin n_err++; $display("FAIL rst_w_rdy got %b want 0", bus.w_rdy); end
        n_vec++; if (bus.w_data_ready !== 1'b0) begin n_err++; $display("FAIL rst_w_ready got %b want 0", bus.w_data_ready); end
        n_vec++; if (bus.wrt_finish !== 1'b0)   begin n_err++; $display("FAIL rst_wrt_finish got %b want 0", bus.wrt_finish); end
        n_vec++; if (busy !== 1'b0)             begin n_err++; $display("FAIL rst_busy got %b want 0", busy); end
        rstn = 1'b1;
        tick();
    endtask

    task automatic test_refill();
        int rl, fl, lk, hb, wl, fn; logic ev, eb; bit rs, ab; logic [31:0] e, g; logic gl;
        do_write(32'h40, 8'd15, 3'd2, 32'h1000, -1, wl, fn, rs, ab);
        n_vec++; if (wl !== 1) begin n_err++; $display("FAIL refill_pre_w_rdy latency got %0d want 1", wl); end
        push_exp(32'h40, 8'd15, 3'd2);
        do_read(32'h40, 8'd15, 3'd2, 1'b0, rl, fl, lk, hb, ev, eb);
        n_vec++; if (rl !== 1)  begin n_err++; $display("FAIL refill_r_rdy latency got %0d want 1", rl); end
        n_vec++; if (fl !== 1)  begin n_err++; $display("FAIL refill_first_beat cycle got %0d want 1", fl); end
        n_vec++; if (lk !== 16) begin n_err++; $display("FAIL refill_last_beat cycle got %0d want 16", lk); end
        n_vec++; if (ev !== 1'b0 || eb !== 1'b0) begin n_err++; $display("FAIL refill_end valid/busy got %b/%b want 0/0", ev, eb); end
        n_vec++; if (got_q.size() !== 16) begin n_err++; $display("FAIL refill_count got %0d want 16", got_q.size()); end
        n_vec++; if (got_q.size() == 16 && got_q[15] !== 32'h100F) begin n_err++; $display("FAIL refill_final_word got %h want 0000100f", got_q[15]); end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); gl = got_last_q.pop_front();
            n_vec++; if (g !== e) begin n_err++; $display("FAIL refill_data got %h want %h", g, e); end
            n_vec++; if (gl !== (exp_q.size() == 0)) begin n_err++; $display("FAIL refill_last_flag got %b want %b", gl, exp_q.size() == 0); end
        end
        exp_q.delete();
    endtask

    task automatic test_write_readback();
        int rl, fl, lk, hb, wl, fn; logic ev, eb; bit rs, ab; logic [31:0] e, g; logic gl;
        do_write(32'h80, 8'd15, 3'd2, 32'hA0, -1, wl, fn, rs, ab);
        n_vec++; if (wl !== 1) begin n_err++; $display("FAIL wr_w_rdy latency got %0d want 1", wl); end
        n_vec++; if (fn !== int'(W_RESP_DELAY)) begin n_err++; $display("FAIL wr_finish latency got %0d want %0d", fn, W_RESP_DELAY); end
        tick();
        n_vec++; if (bus.wrt_finish !== 1'b0) begin n_err++; $display("FAIL wr_finish_pulse_width got %b want 0", bus.wrt_finish); end
        push_exp(32'h80, 8'd15, 3'd2);
        do_read(32'h80, 8'd15, 3'd2, 1'b0, rl, fl, lk, hb, ev, eb);
        n_vec++; if (got_q.size() !== 16) begin n_err++; $display("FAIL wr_rb_count got %0d want 16", got_q.size()); end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); gl = got_last_q.pop_front();
            n_vec++; if (g !== e) begin n_err++; $display("FAIL wr_rb_data got %h want %h", g, e); end
        end
        exp_q.delete();
    endtask

    task automatic test_byte_write();
        int rl, fl, lk, hb, wl, fn; logic ev, eb; bit rs, ab; logic [31:0] e, g; logic gl;
        do_write(32'h100, 8'd1, 3'd2, 32'hDEADBEEF, -1, wl, fn, rs, ab);
        do_write(32'h103, 8'd0, 3'd0, 32'h11223344, -1, wl, fn, rs, ab);
        n_vec++; if (fn !== int'(W_RESP_DELAY)) begin n_err++; $display("FAIL byte_finish latency got %0d want %0d", fn, W_RESP_DELAY); end
        do_write(32'h106, 8'd0, 3'd1, 32'h99887766, -1, wl, fn, rs, ab);
        push_exp(32'h100, 8'd1, 3'd2);
        do_read(32'h100, 8'd1, 3'd2, 1'b0, rl, fl, lk, hb, ev, eb);
        n_vec++; if (got_q.size() == 2 && got_q[0] !== 32'h11ADBEEF) begin n_err++; $display("FAIL byte_lane3 got %h want 11adbeef", got_q[0]); end
        n_vec++; if (got_q.size() !== 2) begin n_err++; $display("FAIL byte_count got %0d want 2", got_q.size()); end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); gl = got_last_q.pop_front();
            n_vec++; if (g !== e) begin n_err++; $display("FAIL subword_data got %h want %h", g, e); end
        end
        exp_q.delete();
    endtask

    task automatic test_ready_toggle();
        int rl, fl, lk, hb; logic ev, eb; logic [31:0] e, g; logic gl;
        push_exp(32'h40, 8'd15, 3'd2);
        do_read(32'h40, 8'd15, 3'd2, 1'b1, rl, fl, lk, hb, ev, eb);
        n_vec++; if (hb !== 0) begin n_err++; $display("FAIL toggle_hold violations got %0d want 0", hb); end
        n_vec++; if (got_q.size() !== 16) begin n_err++; $display("FAIL toggle_count got %0d want 16", got_q.size()); end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); gl = got_last_q.pop_front();
            n_vec++; if (g !== e) begin n_err++; $display("FAIL toggle_data got %h want %h", g, e); end
            n_vec++; if (gl !== (exp_q.size() == 0)) begin n_err++; $display("FAIL toggle_last_flag got %b want %b", gl, exp_q.size() == 0); end
        end
        exp_q.delete();
    endtask

    task automatic test_simultaneous();
        int rl, fl, lk, hb, wl, fn; logic ev, eb; bit rs, ab; logic [31:0] e, g; logic gl;
        bus.r_req = 1'b1; bus.r_addr = 32'h180; bus.r_length = 8'd3; bus.r_size = 3'd2;
        do_write(32'h180, 8'd3, 3'd2, 32'h7700, -1, wl, fn, rs, ab);
        n_vec++; if (wl !== 1)     begin n_err++; $display("FAIL simul_w_rdy latency got %0d want 1", wl); end
        n_vec++; if (rs !== 1'b0)  begin n_err++; $display("FAIL simul_early_r_rdy got %b want 0", rs); end
        push_exp(32'h180, 8'd3, 3'd2);
        do_read(32'h180, 8'd3, 3'd2, 1'b0, rl, fl, lk, hb, ev, eb);
        n_vec++; if (rl !== 1) begin n_err++; $display("FAIL simul_r_rdy after finish got %0d want 1", rl); end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); gl = got_last_q.pop_front();
            n_vec++; if (g !== e) begin n_err++; $display("FAIL simul_data got %h want %h", g, e); end
        end
        exp_q.delete();
    endtask

    task automatic test_reset_mid_burst();
        int rl, fl, lk, hb, wl, fn; logic ev, eb; bit rs, ab; logic [31:0] e, g; logic gl;
        do_write(32'h200, 8'd15, 3'd2, 32'h5500, -1, wl, fn, rs, ab);
        do_write(32'h200, 8'd15, 3'd2, 32'hCC00, 5, wl, fn, rs, ab);
        n_vec++; if (ab !== 1'b1) begin n_err++; $display("FAIL abort_reached got %b want 1", ab); end
        n_vec++; if (busy !== 1'b0 || bus.w_data_ready !== 1'b0 || bus.w_rdy !== 1'b0 || bus.wrt_finish !== 1'b0)
            begin n_err++; $display("FAIL abort_outputs busy/wready/wrdy/fin got %b%b%b%b want 0000", busy, bus.w_data_ready, bus.w_rdy, bus.wrt_finish); end
        rstn = 1'b1;
        tick();
        push_exp(32'h200, 8'd15, 3'd2);
        do_read(32'h200, 8'd15, 3'd2, 1'b0, rl, fl, lk, hb, ev, eb);
        n_vec++; if (got_q.size() == 16 && (got_q[4] !== 32'hCC04 || got_q[5] !== 32'h5505))
            begin n_err++; $display("FAIL abort_boundary got %h/%h want 0000cc04/00005505", got_q[4], got_q[5]); end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); gl = got_last_q.pop_front();
            n_vec++; if (g !== e) begin n_err++; $display("FAIL abort_data got %h want %h", g, e); end
        end
        exp_q.delete();
    endtask

    task automatic test_wrap_and_long();
        int rl, fl, lk, hb, wl, fn; logic ev, eb; bit rs, ab; logic [31:0] e, g; logic gl;
        do_write(32'h3FFC, 8'd1, 3'd2, 32'hBEE0, -1, wl, fn, rs, ab);
        push_exp(32'h0001_3FFC, 8'd1, 3'd2);
        do_read(32'h0001_3FFC, 8'd1, 3'd2, 1'b0, rl, fl, lk, hb, ev, eb);
        n_vec++; if (got_q.size() == 2 && got_q[1] !== 32'hBEE1) begin n_err++; $display("FAIL wrap_word0 got %h want 0000bee1", got_q[1]); end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); gl = got_last_q.pop_front();
            n_vec++; if (g !== e) begin n_err++; $display("FAIL wrap_data got %h want %h", g, e); end
        end
        exp_q.delete();
        do_write(32'h400, 8'd255, 3'd2, 32'h3000, -1, wl, fn, rs, ab);
        n_vec++; if (fn !== int'(W_RESP_DELAY)) begin n_err++; $display("FAIL long_finish latency got %0d want %0d", fn, W_RESP_DELAY); end
        push_exp(32'h400, 8'd255, 3'd2);
        do_read(32'h400, 8'd255, 3'd2, 1'b0, rl, fl, lk, hb, ev, eb);
        n_vec++; if (got_q.size() !== 256) begin n_err++; $display("FAIL long_count got %0d want 256", got_q.size()); end
        n_vec++; if (lk !== 256) begin n_err++; $display("FAIL long_last_cycle got %0d want 256", lk); end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); gl = got_last_q.pop_front();
            n_vec++; if (g !== e) begin n_err++; $display("FAIL long_data got %h want %h", g, e); end
            n_vec++; if (gl !== (exp_q.size() == 0)) begin n_err++; $display("FAIL long_last_flag got %b want %b", gl, exp_q.size() == 0); end
        end
        exp_q.delete();
    endtask

    initial begin
        bus.r_req = 1'b0; bus.r_addr = 32'd0; bus.r_length = 8'd0; bus.r_size = 3'd0; bus.r_data_ready = 1'b0;
        bus.w_req = 1'b0; bus.w_addr = 32'd0; bus.w_length = 8'd0; bus.w_size = 3'd0;
        bus.w_data = 32'd0; bus.w_data_valid = 1'b0;
        test_reset();
        test_refill();
        test_write_readback();
        test_byte_write();
        test_ready_toggle();
        test_simultaneous();
        test_reset_mid_burst();
        test_wrap_and_long();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
